wb_write_queue: RTL
===================

// Module: wb_write_queue
// PURPOSE
//  Writer-side front end for the 8x16 register file write port (writeregsel/writedata/write).
//  Accepts writeback requests through a valid/ready handshake and buffers them in a DEPTH-entry in-order FIFO.
//  Drains one entry per cycle into the register file unless the port is stalled.
//  Sits between the writeback stage and the register file; optionally answers pending-write lookups from operand fetch.
// PARAMETERS
//  DEPTH  4   FIFO entries, power of 2, >= 2
//  DW     16  write data width, matches register file
//  AW     3   register select width (8 registers)
// PORTS
//  clk          in   1      clock, single domain
//  rst_n        in   1      reset, asynchronous, active-low
//  in_valid     in   1      writeback request valid
//  in_ready     out  1      queue can accept request
//  in_regsel    in   AW     destination register
//  in_data      in   DW     write data
//  wr_stall     in   1      register file write port unavailable this cycle
//  flush        in   1      synchronous discard of all pending entries
//  writeregsel  out  AW     to register file
//  writedata    out  DW     to register file
//  write        out  1      to register file write enable
//  count        out  AW     current occupancy, 0..DEPTH
//  lk_regsel    in   AW     lookup register (bypass)
//  lk_hit       out  1      lookup register has a pending write
//  lk_data      out  DW     youngest pending data for lk_regsel
//  err          out  1      sticky handshake-violation flag
// BEHAVIOUR
//  - Reset (rst_n low, async): pointers 0, count 0, err 0; write 0, in_ready 1, lk_hit 0.
//  - Push: in_valid & in_ready at edge stores entry at tail. in_ready = (count < DEPTH) & ~flush; no pop-through when full.
//  - Pop: write = (count != 0) & ~wr_stall & ~flush; writeregsel/writedata = head entry. Head advances on the same edge.
//  - Latency: entry accepted at edge N appears on the write port in cycle N+1 at the earliest. Order is strict FIFO.
//  - Simultaneous push and pop: count unchanged. Pointers wrap modulo DEPTH.
//  - Outputs when empty: writeregsel and writedata are 0.
//  - flush: write gated low in that cycle. Next cycle count = 0 and all entries are dropped. A concurrent push is not accepted.
//  - err: set when in_valid & ~in_ready in cycle N and, in cycle N+1, in_valid is low or in_regsel/in_data changed.
//    Violations in a flush cycle are exempt. err clears only on reset.
//  - Reset asserted mid-operation: all entries lost immediately; no write is issued.
// CONFIGURATION
//  - WBQ_BYPASS_EN defined:
//    - lk_hit = any valid entry with regsel == lk_regsel. lk_data = data of the youngest such entry.
//    - Purely combinational; reflects pre-edge state, excluding the entry being pushed this cycle.
//    - Excluding the head entry that pops this cycle is not required: the register file writes it at the edge.
//  - WBQ_BYPASS_EN undefined: lk_hit = 0 and lk_data = 0; lookup logic not built; ports remain.
// STRUCTURE
//  - Package wbq_pkg: DW, AW, default DEPTH, entry type {regsel[AW], data[DW]}, pointer-width function (clog2 DEPTH).
//  - Sub-module wbq_match: youngest-match priority search over DEPTH entries.
//    Instantiated only under WBQ_BYPASS_EN.
//  - Top level: FIFO storage, pointers, count, handshake monitor.
// TESTING
//  1. Push R3=0x1234 with wr_stall=0 -> next cycle write=1, writeregsel=3, writedata=0x1234; count 1 then 0.
//  2. wr_stall=1, push 4 entries -> in_ready=0 at count 4. Release stall -> 4 writes in push order on 4 consecutive cycles.
//  3. Full queue, push and pop in the same cycle -> push not accepted. Next cycle count=3, in_ready=1.
//  4. 3 pending entries, assert flush -> write=0 that cycle; count=0 next cycle; the queued data is never written.
//  5. WBQ_BYPASS_EN, stall, push R5=0x00AA then R5=0x00BB, lk_regsel=5 -> lk_hit=1, lk_data=0x00BB.
//     lk_regsel=2 -> lk_hit=0.
//  6. Hold in_valid while full, then change in_data -> err=1 and stays 1. Assert rst_n low mid-transfer -> err=0, count=0.

Source files
------------

// File: rtl/wbq_pkg.sv
// Shared widths, queue entry type and pointer sizing for the register file write queue.
package wbq_pkg;

   localparam int unsigned DW        = 16;
   localparam int unsigned AW        = 3;
   localparam int unsigned DEPTH_DEF = 4;

   typedef struct packed {
      logic [AW-1:0] regsel;
      logic [DW-1:0] data;
   } wbq_entry_t;

   function automatic int unsigned ptr_w(input int unsigned depth);
      return (depth > 1) ? $clog2(depth) : 1;
   endfunction

endpackage

// File: rtl/wb_write_queue_if.sv
// Writeback request handshake plus register file write port of the write queue.
interface wb_write_queue_if;
   import wbq_pkg::*;

   logic          in_valid;
   logic          in_ready;
   logic [AW-1:0] in_regsel;
   logic [DW-1:0] in_data;
   logic          wr_stall;
   logic [AW-1:0] writeregsel;
   logic [DW-1:0] writedata;
   logic          write;

   modport master (
      output in_valid, in_regsel, in_data, wr_stall,
      input  in_ready, writeregsel, writedata, write
   );

   modport slave (
      input  in_valid, in_regsel, in_data, wr_stall,
      output in_ready, writeregsel, writedata, write
   );

endinterface

// File: rtl/wbq_match.sv
// Youngest-match search over the occupied queue entries, oldest (head) to youngest.
module wbq_match
   import wbq_pkg::*;
#(
   parameter int unsigned DEPTH = DEPTH_DEF
) (
   input  wbq_entry_t                 entries [DEPTH],
   input  logic [ptr_w(DEPTH)-1:0]    head,
   input  logic [ptr_w(DEPTH):0]      count,
   input  logic [AW-1:0]              regsel,
   output logic                       hit,
   output logic [DW-1:0]              data
);

   localparam int unsigned PW = ptr_w(DEPTH);

   always_comb begin
      logic [PW-1:0] idx;
      hit  = 1'b0;
      data = '0;
      idx  = '0;
      // Later (younger) matches overwrite earlier ones.
      for (int unsigned k = 0; k < DEPTH; k++) begin
         idx = head + PW'(k);
         if (((PW+1)'(k) < count) && (entries[idx].regsel == regsel)) begin
            hit  = 1'b1;
            data = entries[idx].data;
         end
      end
   end

endmodule

// File: rtl/wb_write_queue.sv
// In-order write queue in front of the register file write port.
// Optional pending-write lookup is built when WBQ_BYPASS_EN is defined.
module wb_write_queue
   import wbq_pkg::*;
#(
   parameter int unsigned DEPTH = DEPTH_DEF
) (
   input  logic            clk,
   input  logic            rst_n,
   wb_write_queue_if.slave bus,
   input  logic            flush,
   output logic [AW-1:0]   count,
   input  logic [AW-1:0]   lk_regsel,
   output logic            lk_hit,
   output logic [DW-1:0]   lk_data,
   output logic            err
);

   localparam int unsigned PW = ptr_w(DEPTH);
   localparam int unsigned CW = PW + 1;
   localparam logic [CW-1:0] FullCnt = CW'(DEPTH);

   wbq_entry_t    mem_q [DEPTH];
   logic [PW-1:0] head_q, tail_q;
   logic [CW-1:0] count_q;
   logic          push, pop, not_empty;

   logic          pend_q;
   logic [AW-1:0] regsel_q;
   logic [DW-1:0] data_q;
   logic          err_q;

   assign not_empty       = (count_q != '0);
   assign bus.in_ready    = (count_q != FullCnt) & ~flush;
   assign bus.write       = not_empty & ~bus.wr_stall & ~flush;
   assign bus.writeregsel = not_empty ? mem_q[head_q].regsel : '0;
   assign bus.writedata   = not_empty ? mem_q[head_q].data : '0;
   assign push            = bus.in_valid & bus.in_ready;
   assign pop             = bus.write;
   assign count           = AW'(count_q);
   assign err             = err_q;

   always_ff @(posedge clk) begin
      if (push) begin
         mem_q[tail_q] <= '{regsel: bus.in_regsel, data: bus.in_data};
      end
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         head_q  <= '0;
         tail_q  <= '0;
         count_q <= '0;
      end else if (flush) begin
         head_q  <= '0;
         tail_q  <= '0;
         count_q <= '0;
      end else begin
         if (push) tail_q <= tail_q + PW'(1);
         if (pop)  head_q <= head_q + PW'(1);
         unique case ({push, pop})
            2'b10:   count_q <= count_q + CW'(1);
            2'b01:   count_q <= count_q - CW'(1);
            default: count_q <= count_q;
         endcase
      end
   end

   // A request stalled outside a flush must be held unchanged into the next cycle.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         pend_q   <= 1'b0;
         regsel_q <= '0;
         data_q   <= '0;
         err_q    <= 1'b0;
      end else begin
         pend_q   <= bus.in_valid & ~bus.in_ready & ~flush;
         regsel_q <= bus.in_regsel;
         data_q   <= bus.in_data;
         if (pend_q && !flush &&
             (!bus.in_valid || (bus.in_regsel != regsel_q) || (bus.in_data != data_q))) begin
            err_q <= 1'b1;
         end
      end
   end

`ifdef WBQ_BYPASS_EN
   wbq_match #(
      .DEPTH (DEPTH)
   ) u_match (
      .entries (mem_q),
      .head    (head_q),
      .count   (count_q),
      .regsel  (lk_regsel),
      .hit     (lk_hit),
      .data    (lk_data)
   );
`else
   logic unused_lk;
   assign unused_lk = ^lk_regsel;
   assign lk_hit    = 1'b0;
   assign lk_data   = '0;
`endif

endmodule
